// File: rtl/vga_pattern_pkg.sv
// +----------------------------------------------------------------------+
// | vga_pattern_pkg: mode codes, colour-bar table and bar FSM state type |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package vga_pattern_pkg;

  localparam logic [1:0] MODE_GRAD   = 2'd0;
  localparam logic [1:0] MODE_BARS   = 2'd1;
  localparam logic [1:0] MODE_CHECK  = 2'd2;
  localparam logic [1:0] MODE_SCROLL = 2'd3;

  // 12-bit {R,G,B} per bar, left to right
  localparam logic [11:0] BAR_RGB [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
    12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } bar_state_e;

endpackage

`default_nettype wire

// File: rtl/vga_bar_counter.sv
// +----------------------------------------------------------------------+
// | vga_bar_counter: tracks which of the 8 colour bars the current       |
// | active pixel falls in; restarts on every rising edge of de_i.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module vga_bar_counter
  import vga_pattern_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       de_i,
  output logic [2:0] bar_idx_o
);

  localparam int             PCW        = (H_ACTIVE / 8 > 1) ? $clog2(H_ACTIVE / 8) : 1;
  localparam logic [PCW-1:0] c_PIX_LAST = PCW'(H_ACTIVE / 8 - 1);

  bar_state_e     state_q, state_d;
  logic [PCW-1:0] pix_cnt_q, pix_cnt_d;
  logic [2:0]     bar_idx_q, bar_idx_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      pix_cnt_q <= '0;
      bar_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  // The registered values describe the pixel captured on the same edge.
  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    bar_idx_d = bar_idx_q;
    case (state_q)
      IDLE: begin
        if (de_i) begin
          state_d   = RUN;
          pix_cnt_d = '0;
          bar_idx_d = '0;
        end
      end
      RUN: begin
        if (!de_i) begin
          state_d   = IDLE;
          pix_cnt_d = '0;
          bar_idx_d = '0;
        end else if (pix_cnt_q == c_PIX_LAST) begin
          pix_cnt_d = '0;
          if (bar_idx_q != 3'd7) begin
            bar_idx_d = bar_idx_q + 3'd1;
          end
        end else begin
          pix_cnt_d = pix_cnt_q + PCW'(1);
        end
      end
    endcase
  end

  assign bar_idx_o = bar_idx_q;

endmodule

`default_nettype wire

// File: rtl/vga_pattern_gen.sv
// +----------------------------------------------------------------------+
// | vga_pattern_gen: four selectable test patterns on 4-bit RGB, with    |
// | syncs/DE delayed 2 cycles. Define VGA_PATTERN_BORDER_EN for a white  |
// | one-pixel frame border.                                              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module vga_pattern_gen
  import vga_pattern_pkg::*;
#(
  parameter int   HSZ      = 10,
  parameter int   VSZ      = 10,
  parameter int   H_ACTIVE = 640,
  parameter int   V_ACTIVE = 480,
  parameter int   CHK_LOG2 = 5,
  parameter int   FCW      = 8,
  parameter logic SYNC_RST = 1'b1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [HSZ-1:0] hcount_i,
  input  logic [VSZ-1:0] vcount_i,
  input  logic           de_i,
  input  logic           hsync_i,
  input  logic           vsync_i,
  input  logic [1:0]     mode_i,
  output logic [3:0]     r_o,
  output logic [3:0]     g_o,
  output logic [3:0]     b_o,
  output logic           de_o,
  output logic           hsync_o,
  output logic           vsync_o,
  output logic [FCW-1:0] frame_o
);

  logic [HSZ-1:0] hcount_q, hcount_d;
  logic [VSZ-1:0] vcount_q, vcount_d;
  logic           de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d;
  logic [1:0]     mode_q, mode_d;
  logic [FCW-1:0] frame_q, frame_d;
  logic [11:0]    rgb_q, rgb_d;
  logic           de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d;

  logic [2:0]     w_bar_idx;
  logic           w_frame_start;
  logic [7:0]     w_scroll;
  logic [11:0]    w_rgb_sel;
  logic           w_unused_bits;

  vga_bar_counter #(
    .H_ACTIVE (H_ACTIVE)
  ) u_bar_counter (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .de_i      (de_i),
    .bar_idx_o (w_bar_idx)
  );

  assign w_frame_start = de_i && (hcount_i == '0) && (vcount_i == '0);

  // Mode and frame count change only at frame start so a frame never tears.
  always_comb begin
    hcount_d = hcount_i;
    vcount_d = vcount_i;
    de1_d    = de_i;
    hs1_d    = hsync_i;
    vs1_d    = vsync_i;
    mode_d   = mode_q;
    frame_d  = frame_q;
    if (w_frame_start) begin
      mode_d  = mode_i;
      frame_d = frame_q + FCW'(1);
    end
    de2_d = de1_q;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
  end

  assign w_scroll = hcount_q[7:0] + 8'(frame_q);

`ifdef VGA_PATTERN_BORDER_EN
  localparam logic [HSZ-1:0] c_H_LAST = HSZ'(H_ACTIVE - 1);
  localparam logic [VSZ-1:0] c_V_LAST = VSZ'(V_ACTIVE - 1);
`endif

  always_comb begin
    w_rgb_sel = '0;
    case (mode_q)
      MODE_GRAD:   w_rgb_sel = {hcount_q[7:4], vcount_q[7:4], 4'h6};
      MODE_BARS:   w_rgb_sel = BAR_RGB[w_bar_idx];
      MODE_CHECK:  w_rgb_sel = (hcount_q[CHK_LOG2] ^ vcount_q[CHK_LOG2]) ? 12'hFFF : 12'h000;
      MODE_SCROLL: w_rgb_sel = {w_scroll[7:4], vcount_q[7:4], frame_q[5:2]};
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if ((hcount_q == '0) || (hcount_q == c_H_LAST) ||
        (vcount_q == '0) || (vcount_q == c_V_LAST)) begin
      w_rgb_sel = 12'hFFF;
    end
`endif
    rgb_d = de1_q ? w_rgb_sel : 12'h000;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hcount_q <= '0;
      vcount_q <= '0;
      de1_q    <= 1'b0;
      hs1_q    <= SYNC_RST;
      vs1_q    <= SYNC_RST;
      mode_q   <= MODE_GRAD;
      frame_q  <= '0;
      rgb_q    <= '0;
      de2_q    <= 1'b0;
      hs2_q    <= SYNC_RST;
      vs2_q    <= SYNC_RST;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      de1_q    <= de1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      mode_q   <= mode_d;
      frame_q  <= frame_d;
      rgb_q    <= rgb_d;
      de2_q    <= de2_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
    end
  end

  // Upper coordinate bits only matter for the optional border compare.
  assign w_unused_bits = ^{hcount_q, vcount_q};

  assign r_o     = rgb_q[11:8];
  assign g_o     = rgb_q[7:4];
  assign b_o     = rgb_q[3:0];
  assign de_o    = de2_q;
  assign hsync_o = hs2_q;
  assign vsync_o = vs2_q;
  assign frame_o = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
// +----------------------------------------------------------------------+
// | tb_vga_pattern_gen: scoreboard bench for vga_pattern_gen             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_vga_pattern_gen;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam logic [11:0] C_BARS [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };
  localparam int C_LINES [6] = '{0, 31, 32, 71, 479, 490};

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [9:0] hcount_i, vcount_i;
  logic       de_i, hsync_i, vsync_i;
  logic [1:0] mode_i;
  logic [3:0] r_o, g_o, b_o;
  logic       de_o, hsync_o, vsync_o;
  logic [7:0] frame_o;

  vga_pattern_gen dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .hcount_i (hcount_i),
    .vcount_i (vcount_i),
    .de_i     (de_i),
    .hsync_i  (hsync_i),
    .vsync_i  (vsync_i),
    .mode_i   (mode_i),
    .r_o      (r_o),
    .g_o      (g_o),
    .b_o      (b_o),
    .de_o     (de_o),
    .hsync_o  (hsync_o),
    .vsync_o  (vsync_o),
    .frame_o  (frame_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          x;
    int          y;
    logic        chk;
    logic [14:0] exp;
  } sb_t;

  sb_t        sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [1:0] m_mode;
  logic [7:0] m_frame;
  logic       m_de_prev;
  int         m_run;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_rgb(input int x, input int y, input logic de);
    logic [11:0] c;
    logic [7:0]  xs;
    int          bar;
    xs  = x[7:0] + m_frame;
    bar = m_run / 80;
    if (bar > 7) bar = 7;
    case (m_mode)
      2'd0:    c = {x[7:4], y[7:4], 4'h6};
      2'd1:    c = C_BARS[bar];
      2'd2:    c = (x[5] ^ y[5]) ? 12'hFFF : 12'h000;
      default: c = {xs[7:4], y[7:4], m_frame[5:2]};
    endcase
`ifdef VGA_PATTERN_BORDER_EN
    if (x == 0 || x == H_ACTIVE - 1 || y == 0 || y == V_ACTIVE - 1) c = 12'hFFF;
`endif
    if (!de) c = 12'h000;
    return c;
  endfunction

  function automatic logic [31:0] observed();
    return {9'd0, frame_o, r_o, g_o, b_o, de_o, hsync_o, vsync_o};
  endfunction

  // One pixel slot: compare the output due now, optionally pulse reset, drive.
  task automatic drive(input int x, input int y, input logic de, input logic hs,
                       input logic vs, input logic chk, input logic rst_now);
    sb_t e;
    sb_t n;
    @(negedge clk_i);
    if (sb.size() == 2) begin
      e = sb.pop_front();
      if (e.chk)
        check_eq($sformatf("pix m%0d x=%0d y=%0d", m_mode, e.x, e.y), observed(),
                 {9'd0, m_frame, e.exp});
    end
    if (rst_now) begin
      rst_i = 1'b1;
      #1;
      check_eq("async_rst", observed(), {9'd0, 8'd0, 12'h000, 1'b0, 1'b1, 1'b1});
      rst_i = 1'b0;
      sb.delete();
      m_mode = 2'd0; m_frame = 8'd0; m_de_prev = 1'b0; m_run = 0;
    end
    hcount_i = x[9:0];
    vcount_i = y[9:0];
    de_i     = de;
    hsync_i  = hs;
    vsync_i  = vs;
    if (de && x == 0 && y == 0) begin
      m_mode  = mode_i;
      m_frame = m_frame + 8'd1;
    end
    if (de) m_run = m_de_prev ? m_run + 1 : 0;
    m_de_prev = de;
    n.x   = x;
    n.y   = y;
    n.chk = chk;
    n.exp = {model_rgb(x, y, de), de, hs, vs};
    sb.push_back(n);
  endtask

  task automatic run_line(input int y, input int rst_x);
    logic de, hs, vs, chk;
    for (int x = 0; x < 720; x++) begin
      de  = (y < V_ACTIVE) && (x < H_ACTIVE);
      hs  = !(x >= 656 && x < 672);
      vs  = !(y >= 490 && y < 492);
      chk = (de && (x inside {0, 15, 31, 32, 53, 79, 80, 159, 160, 560, 639})) ||
            x == 660 || x == 700;
      drive(x, y, de, hs, vs, chk, x == rst_x);
    end
  endtask

  // mode_after is requested just before the last active line (mid-frame).
  task automatic run_frame(input logic [1:0] mode_after, input int rst_line);
    for (int i = 0; i < 6; i++) begin
      if (C_LINES[i] == 479) mode_i = mode_after;
      run_line(C_LINES[i], (C_LINES[i] == rst_line) ? 300 : -1);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    hcount_i = '0; vcount_i = '0; de_i = 1'b0; hsync_i = 1'b1; vsync_i = 1'b1;
    mode_i = 2'd0;
    m_mode = 2'd0; m_frame = 8'd0; m_de_prev = 1'b0; m_run = 0;
    repeat (2) @(negedge clk_i);
    check_eq("reset", observed(), {9'd0, 8'd0, 12'h000, 1'b0, 1'b1, 1'b1});
    rst_i = 1'b0;

    run_frame(2'd1, -1);   // gradient; bars requested late in frame
    run_frame(2'd2, -1);   // bars
    run_frame(2'd1, -1);   // checkerboard
    run_frame(2'd3, 71);   // bars, reset mid-line, then gradient fallback
    run_frame(2'd3, -1);   // scroll
    run_frame(2'd3, -1);
    run_frame(2'd3, -1);

    do begin
      drive(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      drive(640, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    end while (m_frame != 8'd0);
    repeat (3) drive(700, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("frame_wrap", {24'd0, frame_o}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
